// File: rtl/opb_pkg.sv
// Shared OPB types and helpers: FSM state encoding, big-endian bus lane
// conversion and the address-window match used by the register bank.
package opb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } opb_state_t;

    // OPB numbers bits MSB-first; bus bit 0 is user bit 31.
    function automatic logic [31:0] to_le32(input logic [0:31] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[31-i] = d[i];
        end
        return r;
    endfunction

    function automatic logic [0:31] to_be32(input logic [31:0] d);
        logic [0:31] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = d[31-i];
        end
        return r;
    endfunction

    // BE[0] covers DBus[0:7], the most significant user byte.
    function automatic logic [3:0] to_le_be(input logic [0:3] be);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[3-i] = be[i];
        end
        return r;
    endfunction

    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] high);
        return (addr & ~(high - base)) == base;
    endfunction

endpackage

// File: rtl/opb_register_bank_if.sv
// OPB slave-side bus bundle; the master modport is what a bus model or
// arbiter drives, the slave modport is what the register bank consumes.
interface opb_register_bank_if;

    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_reg_cell.sv
// One software register: byte-enable merge, optional read-only or
// self-clearing behaviour, and a one-cycle write strobe.
module opb_reg_cell #(
    parameter logic [31:0] RESET_VAL = 32'h0,
    parameter bit          IS_RO     = 1'b0,
    parameter bit          IS_PULSE  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] data_q,
    output logic        wr_stb
);

    // Read-only cells are sourced elsewhere; their stored copy stays zero.
    localparam logic [31:0] INIT_VAL = IS_RO ? 32'h0 : RESET_VAL;

    logic [31:0] merged;

    always_comb begin
        merged = data_q;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    // The strobe doubles as the "written last cycle" flag that lets a pulse
    // register fall back to its reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= INIT_VAL;
            wr_stb <= 1'b0;
        end else begin
            wr_stb <= wr_en & ~IS_RO;
            if (!IS_RO && wr_en) begin
                data_q <= merged;
            end else if (!IS_RO && IS_PULSE && wr_stb) begin
                data_q <= RESET_VAL;
            end
        end
    end

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave exposing C_NUM_REGS 32-bit software registers in one address
// window, with byte-enable writes, per-register strobes and error acks.
module opb_register_bank
    import opb_pkg::*;
#(
    parameter logic [31:0]              C_BASEADDR   = 32'h01020000,
    parameter logic [31:0]              C_HIGHADDR   = 32'h010200FF,
    parameter int                       C_OPB_AWIDTH = 32,
    parameter int                       C_OPB_DWIDTH = 32,
    parameter int                       C_NUM_REGS   = 4,
    parameter logic [63:0]              C_RO_MASK    = 64'h0,
    parameter logic [63:0]              C_PULSE_MASK = 64'h0,
    parameter logic [C_NUM_REGS*32-1:0] C_RESET_VAL  = '0
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst,
    opb_register_bank_if.slave         bus,
    output logic [C_NUM_REGS*32-1:0]   user_data_out,
    input  logic [C_NUM_REGS*32-1:0]   user_data_in,
    output logic [C_NUM_REGS-1:0]      user_wr_stb
);

    localparam logic [31:0] WIN_MASK = C_HIGHADDR - C_BASEADDR;

    opb_state_t state_q, state_d;

    logic [C_OPB_AWIDTH-1:0] abus_le;
    logic [C_OPB_DWIDTH-1:0] wdata_le;
    logic [3:0]              be_le;
    logic [31:0]             word_idx;
    logic                    hit;
    logic                    ack_fire;
    logic                    wr_fire;

    logic [31:0] idx_q;
    logic        rnw_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        unmapped_q;
    logic [31:0] ro_sample_q;

    logic [31:0] ro_lane;
    logic [31:0] rd_word;
    logic [31:0] cell_q [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] cell_wr;

    logic unused_seq;

    assign abus_le    = to_le32(bus.OPB_ABus);
    assign wdata_le   = to_le32(bus.OPB_DBus);
    assign be_le      = to_le_be(bus.OPB_BE);
    assign hit        = bus.OPB_select & addr_in_window(abus_le, C_BASEADDR, C_HIGHADDR);
    assign word_idx   = (abus_le & WIN_MASK) >> 2;
    assign unused_seq = bus.OPB_seqAddr;

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack is combinational on select so a master that drops select during
    // ACK aborts cleanly; reset in that cycle also suppresses it.
    always_comb begin
        state_d  = state_q;
        ack_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d  = ST_IDLE;
                ack_fire = bus.OPB_select & ~OPB_Rst;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            idx_q       <= '0;
            rnw_q       <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            unmapped_q  <= 1'b0;
            ro_sample_q <= '0;
        end else if (state_q == ST_IDLE && hit) begin
            idx_q       <= word_idx;
            rnw_q       <= bus.OPB_RNW;
            be_q        <= be_le;
            wdata_q     <= wdata_le;
            unmapped_q  <= (word_idx >= 32'(C_NUM_REGS));
            ro_sample_q <= ro_lane;
        end
    end

    always_comb begin
        ro_lane = '0;
        rd_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word_idx == 32'(i)) begin
                ro_lane = user_data_in[32*i +: 32];
            end
            if (idx_q == 32'(i)) begin
                rd_word = C_RO_MASK[i] ? ro_sample_q : cell_q[i];
            end
        end
    end

    assign wr_fire = ack_fire & ~rnw_q & ~unmapped_q;

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_cell
            assign cell_wr[gi] = wr_fire && (idx_q == 32'(gi));

            opb_reg_cell #(
                .RESET_VAL (C_RESET_VAL[32*gi +: 32]),
                .IS_RO     (C_RO_MASK[gi]),
                .IS_PULSE  (C_PULSE_MASK[gi] & ~C_RO_MASK[gi])
            ) u_cell (
                .clk    (OPB_Clk),
                .rst    (OPB_Rst),
                .wr_en  (cell_wr[gi]),
                .be     (be_q),
                .wdata  (wdata_q),
                .data_q (cell_q[gi]),
                .wr_stb (user_wr_stb[gi])
            );

            assign user_data_out[32*gi +: 32] = cell_q[gi];
        end
    endgenerate

    assign bus.Sl_xferAck = ack_fire;
    assign bus.Sl_errAck  = ack_fire & unmapped_q;
    assign bus.Sl_DBus    = (ack_fire & rnw_q & ~unmapped_q) ? to_be32(rd_word) : '0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

endmodule
